regfile_wb_arbiter: RTL



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request bundle for the register file write-port arbiter.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits. The issue stage sets a bit and the committed
// write clears it. Two hazard query ports are provided.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  output logic          issue_ready_o,
  input  logic          clr_valid_i,
  input  logic [AW-1:0] clr_rd_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  logic [NREG-1:0] sb_q, sb_d;
  logic [NREG-1:0] set_vec, clr_vec;

  assign issue_ready_o = (issue_rd_i == '0) | !sb_q[issue_rd_i];
  assign rs1_busy_o    = sb_q[rs1_addr_i];
  assign rs2_busy_o    = sb_q[rs2_addr_i];

  // Next scoreboard: clear the committed register, then set the claimed one so a
  // same-cycle claim survives. x0 never becomes pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid_i && issue_ready_o && (issue_rd_i != '0)) set_vec[issue_rd_i] = 1'b1;
    if (clr_valid_i) clr_vec[clr_rd_i] = 1'b1;
    sb_d    = (sb_q & ~clr_vec) | set_vec;
    sb_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sb_q <= '0;
    else          sb_q <= sb_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline (src0)
// and a long-latency unit (src1). src0 normally wins; src1 is forced through
// after MAX_WAIT consecutive denied cycles. The write port is registered.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREG     = regfile_pkg::NREG,
  parameter int AW       = regfile_pkg::AW,
  parameter int DW       = regfile_pkg::DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_src0_valid,
  input  logic [AW-1:0] i_src0_rd,
  input  logic [DW-1:0] i_src0_data,
  output logic          o_src0_ready,
  input  logic          i_src1_valid,
  input  logic [AW-1:0] i_src1_rd,
  input  logic [DW-1:0] i_src1_data,
  output logic          o_src1_ready,
  input  logic          i_issue_valid,
  input  logic [AW-1:0] i_issue_rd,
  output logic          o_issue_ready,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic [AW-1:0] i_rs2_addr,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic          o_WE3,
  output logic [AW-1:0] o_A3_addr,
  output logic [DW-1:0] o_WD3_data
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  wb_req_t src0, src1, sel;
  logic    override, acc0, acc1;

  logic [WCW-1:0] wait_q, wait_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;

  assign src0 = '{valid: i_src0_valid, rd: i_src0_rd, data: i_src0_data};
  assign src1 = '{valid: i_src1_valid, rd: i_src1_rd, data: i_src1_data};

  assign override     = (wait_q == WCW'(MAX_WAIT)) && src1.valid;
  assign o_src0_ready = !override;
  assign o_src1_ready = !src0.valid || override;
  assign acc0         = src0.valid && o_src0_ready;
  assign acc1         = src1.valid && o_src1_ready && !acc0;

  // Select the accepted request and form the next write-port values and starvation count.
  always_comb begin
    sel    = acc1 ? src1 : src0;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (acc0 || acc1) begin
      we_d   = (sel.rd != '0);
      addr_d = sel.rd;
      data_d = sel.data;
    end
    wait_d = '0;
    if (src1.valid && !acc1) wait_d = (wait_q == WCW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
  end

  // Registered write port and src1 wait counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wait_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wait_q <= wait_d;
    end
  end

  assign o_WE3      = we_q;
  assign o_A3_addr  = addr_q;
  assign o_WD3_data = data_q;

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk_i         (i_clk),
    .rst_n_i       (i_rst_n),
    .issue_valid_i (i_issue_valid),
    .issue_rd_i    (i_issue_rd),
    .issue_ready_o (o_issue_ready),
    .clr_valid_i   (we_q),
    .clr_rd_i      (addr_q),
    .rs1_addr_i    (i_rs1_addr),
    .rs2_addr_i    (i_rs2_addr),
    .rs1_busy_o    (o_rs1_busy),
    .rs2_busy_o    (o_rs2_busy)
  );

endmodule
